// File: rtl/qam_mapper_param.sv
// Serial-bit QAM mapper: optional LFSR scrambling, Gray-coded QPSK/16QAM/64QAM
// mapping per axis, and a held ready/valid symbol output.
module qam_mapper_param #(
    parameter int                OUT_W     = 8,
    parameter int                LFSR_W    = 7,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 7'h48,
    parameter int                SCALE     = 16,
    parameter logic [LFSR_W-1:0] LFSR_RST  = {LFSR_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [LFSR_W-1:0]       lfsr_seed,
    input  logic                    lfsr_load,
    input  logic [1:0]              mode,
    input  logic                    scr_en,
    input  logic                    in_bit,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] I_out,
    output logic signed [OUT_W-1:0] Q_out,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    mode_err
);

    if (32'sd7 * SCALE > (32'sd1 <<< (OUT_W - 1)) - 32'sd1) begin : g_scale_check
        $error("qam_mapper_param: 7*SCALE does not fit the signed OUT_W range");
    end

    // Gray-decode one axis and scale its level 2b-(2^k-1) to the output width.
    function automatic logic signed [OUT_W-1:0] map_axis(input logic [2:0] g, input logic [1:0] k);
        logic [2:0] b;
        int         lvl;
        b[2] = g[2];
        b[1] = g[1] ^ b[2];
        b[0] = g[0] ^ b[1];
        lvl  = (32'sd2 * $signed({29'd0, b})) - ((32'sd1 <<< k) - 32'sd1);
        return OUT_W'(lvl * SCALE);
    endfunction

    logic [LFSR_W-1:0]       lfsr_r;
    logic [2:0]              bit_cnt_r;
    logic [4:0]              sym_r;
    logic [1:0]              mode_r;
    logic                    live_r;
    logic                    mode_err_r;
    logic signed [OUT_W-1:0] i_out_r;
    logic signed [OUT_W-1:0] q_out_r;
    logic                    out_valid_r;
    logic                    out_last_r;

    logic [1:0]              eff_mode_s;
    logic [2:0]              bps_s;
    logic                    fb_s;
    logic                    data_bit_s;
    logic                    complete_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic [LFSR_W-1:0]       seed_s;
    logic [5:0]              gather_s;
    logic [2:0]              i_g_s;
    logic [2:0]              q_g_s;
    logic [1:0]              k_s;

    // Symbol geometry, scrambler feedback and input handshake.
    always_comb begin
        eff_mode_s = (bit_cnt_r == 3'd0) ? mode : mode_r;
        case (eff_mode_s)
            2'b01:   bps_s = 3'd4;
            2'b10:   bps_s = 3'd6;
            default: bps_s = 3'd2;
        endcase
        fb_s       = ^(lfsr_r & LFSR_TAPS);
        data_bit_s = scr_en ? (in_bit ^ fb_s) : in_bit;
        complete_s = (bit_cnt_r == (bps_s - 3'd1)) || in_last;
        in_ready_s = live_r && !lfsr_load && !(complete_s && out_valid_r && !out_ready);
        accept_s   = in_valid && in_ready_s;
        seed_s     = (lfsr_seed == {LFSR_W{1'b0}}) ? {LFSR_W{1'b1}} : lfsr_seed;
        // Left-justify into BPS bits: a short final symbol is zero-padded.
        gather_s   = {sym_r, data_bit_s} << (bps_s - 3'd1 - bit_cnt_r);
    end

    // Split the gathered symbol into I (first half) and Q (second half) Gray codes.
    always_comb begin
        case (eff_mode_s)
            2'b01: begin
                i_g_s = {1'b0, gather_s[3:2]};
                q_g_s = {1'b0, gather_s[1:0]};
                k_s   = 2'd2;
            end
            2'b10: begin
                i_g_s = gather_s[5:3];
                q_g_s = gather_s[2:0];
                k_s   = 2'd3;
            end
            default: begin
                i_g_s = {2'b00, gather_s[1]};
                q_g_s = {2'b00, gather_s[0]};
                k_s   = 2'd1;
            end
        endcase
    end

    // Bit counter, partial symbol, held mode, scrambler state and error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r     <= LFSR_RST;
            bit_cnt_r  <= 3'd0;
            sym_r      <= 5'd0;
            mode_r     <= 2'b00;
            live_r     <= 1'b0;
            mode_err_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
            if (lfsr_load) begin
                lfsr_r    <= seed_s;
                bit_cnt_r <= 3'd0;
                sym_r     <= 5'd0;
            end else if (accept_s) begin
                if (bit_cnt_r == 3'd0) begin
                    mode_r <= mode;
                    if (mode == 2'b11) begin
                        mode_err_r <= 1'b1;
                    end
                end
                if (in_last) begin
                    lfsr_r <= seed_s;
                end else if (scr_en) begin
                    lfsr_r <= {lfsr_r[LFSR_W-2:0], fb_s};
                end
                if (complete_s) begin
                    bit_cnt_r <= 3'd0;
                    sym_r     <= 5'd0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    sym_r     <= {sym_r[3:0], data_bit_s};
                end
            end
        end
    end

    // Output symbol register: load on completion, hold until taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_out_r     <= {OUT_W{1'b0}};
            q_out_r     <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (accept_s && complete_s && !lfsr_load) begin
            i_out_r     <= map_axis(i_g_s, k_s);
            q_out_r     <= map_axis(q_g_s, k_s);
            out_valid_r <= 1'b1;
            out_last_r  <= in_last;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign I_out     = i_out_r;
    assign Q_out     = q_out_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign mode_err  = mode_err_r;

endmodule

// File: tb/tb_qam_mapper_param.sv
// Bench for qam_mapper_param: vector table plus corner sequences, with a
// scoreboard queue checked whenever a symbol is handed off.
module tb_qam_mapper_param;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [6:0]        lfsr_seed;
    logic              lfsr_load;
    logic [1:0]        mode;
    logic              scr_en;
    logic              in_bit;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic signed [7:0] I_out;
    logic signed [7:0] Q_out;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              mode_err;

    qam_mapper_param dut (
        .clk(clk), .reset_n(reset_n), .lfsr_seed(lfsr_seed), .lfsr_load(lfsr_load),
        .mode(mode), .scr_en(scr_en), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .I_out(I_out), .Q_out(Q_out),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         nbits;
        logic [5:0] bits;      // first bit sent is bits[5]
        logic       last;
        int         exp_i;
        int         exp_q;
        logic       exp_last;
    } vec_t;

    typedef struct {
        int   i;
        int   q;
        logic last;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input int q, input logic l);
        exp_t x;
        x.i = i; x.q = q; x.last = l;
        sb.push_back(x);
    endtask

    task automatic send_bit(input logic b, input logic l);
        int n;
        n = 0;
        in_bit = b; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0d expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Scoreboard: every handed-off symbol must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_symbol: got I=%0d Q=%0d expected none", I_out, Q_out);
            end else begin
                e = sb.pop_front();
                check("I_out", I_out, e.i);
                check("Q_out", Q_out, e.q);
                check("out_last", out_last, e.last);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b00, 2, 6'b100000, 1'b0,  16,  -16, 1'b0};
        vecs[1]  = '{2'b00, 2, 6'b010000, 1'b0, -16,   16, 1'b0};
        vecs[2]  = '{2'b00, 2, 6'b110000, 1'b0,  16,   16, 1'b0};
        vecs[3]  = '{2'b01, 4, 6'b100100, 1'b0,  48,  -16, 1'b0};
        vecs[4]  = '{2'b01, 4, 6'b001100, 1'b0, -48,   16, 1'b0};
        vecs[5]  = '{2'b01, 4, 6'b011000, 1'b0, -16,   48, 1'b0};
        vecs[6]  = '{2'b10, 6, 6'b100000, 1'b0, 112, -112, 1'b0};
        vecs[7]  = '{2'b10, 6, 6'b011010, 1'b0, -48,  -16, 1'b0};
        vecs[8]  = '{2'b10, 6, 6'b110101, 1'b0,  16,   80, 1'b0};
        vecs[9]  = '{2'b01, 1, 6'b100000, 1'b1,  48,  -48, 1'b1};
        vecs[10] = '{2'b10, 2, 6'b110000, 1'b1,  16, -112, 1'b1};
        vecs[11] = '{2'b11, 2, 6'b100000, 1'b0,  16,  -16, 1'b0};

        reset_n = 1'b0; lfsr_seed = 7'h00; lfsr_load = 1'b0; mode = 2'b00;
        scr_en = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;

        // Reset state and in_ready release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_I", I_out, 0);
        check("rst_Q", Q_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_mode_err", mode_err, 0);
        reset_n = 1'b1;
        check("rst_in_ready_low", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_high", in_ready, 1);

        // Scrambled QPSK; the colliding load must swallow the in_valid bit.
        scr_en = 1'b1; mode = 2'b00; lfsr_seed = 7'h01;
        lfsr_load = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(negedge clk);
        check("load_in_ready", in_ready, 0);
        @(posedge clk); #1;
        lfsr_load = 1'b0; in_valid = 1'b0;
        push_exp(-16, -16, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        push_exp(-16, 16, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        scr_en = 1'b0;

        // Mode is held from the first bit of a symbol.
        mode = 2'b01;
        send_bit(1'b1, 1'b0);
        mode = 2'b00;
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        push_exp(48, -16, 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mode_err_clear", mode_err, 0);

        // Vector table.
        for (int v = 0; v < 12; v++) begin
            mode = vecs[v].mode;
            for (int j = 0; j < vecs[v].nbits; j++) begin
                if (j == vecs[v].nbits - 1)
                    push_exp(vecs[v].exp_i, vecs[v].exp_q, vecs[v].exp_last);
                send_bit(vecs[v].bits[5-j], (j == vecs[v].nbits - 1) && vecs[v].last);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("mode_err_set", mode_err, 1);

        // Backpressure: completing bit stalls while the held symbol waits.
        mode = 2'b00; out_ready = 1'b0;
        push_exp(16, -16, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        push_exp(-16, 16, 1'b0);
        in_bit = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_valid", out_valid, 1);
        @(negedge clk);
        check("stall_hold_I", I_out, 16);
        check("stall_hold_Q", Q_out, -16);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        // Asynchronous reset with a held symbol and a partial one.
        #1;
        out_ready = 1'b0; mode = 2'b00;
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_I", I_out, 0);
        check("arst_Q", Q_out, 0);
        check("arst_last", out_last, 0);
        check("arst_mode_err", mode_err, 0);
        check("arst_in_ready", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        mode = 2'b01;
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        push_exp(48, -16, 1'b0);
        send_bit(1'b1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
